// File: rtl/serial_demux8_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_demux8_if
//  Brief    : Serial-in / word-out bundle for the 1:N deserializer.
//             slave  = deserializer side, master = link source + consumer side.
//  Revision : 1.0  initial release
// ============================================================================
interface serial_demux8_if #(
  parameter int N     = 8,
  parameter int SEL_W = $clog2(N)
);
  logic             clear;
  logic             din;
  logic             din_valid;
  logic             din_ready;
  logic [SEL_W-1:0] sel;
  logic [N-1:0]     dout;
  logic             dout_valid;
  logic             dout_ready;

  modport slave (
    input  clear, din, din_valid, dout_ready,
    output din_ready, sel, dout, dout_valid
  );

  modport master (
    output clear, din, din_valid, dout_ready,
    input  din_ready, sel, dout, dout_valid
  );
endinterface
`default_nettype wire

// File: rtl/serial_demux8.sv
`default_nettype none
// ============================================================================
//  Module   : serial_demux8
//  Brief    : 1:N serial deserializer. Accepted bits fill slots 0..N-1 of an
//             assembly word LSB-first; each completed word is held in a
//             valid/ready output register until consumed.
//  Revision : 1.0  initial release
// ============================================================================
module serial_demux8 #(
  parameter int N     = 8,
  parameter int SEL_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_demux8_if.slave  bus
);

  localparam logic [SEL_W-1:0] C_SEL_LAST = SEL_W'(N - 1);

  // Slot N-1 never needs storage: the completing bit goes straight into dout.
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N-2:0]     asm_q, asm_d;
  logic [N-1:0]     dout_q, dout_d;
  logic             valid_q, valid_d;

  logic w_last;
  logic w_din_ready;
  logic w_accept;
  logic w_consume;

  assign w_last      = (sel_q == C_SEL_LAST);
  // Only the completing bit stalls, and only while an unconsumed word is
  // still waiting; clear always refuses the bit it overrides.
  assign w_din_ready = !bus.clear && !(w_last && valid_q && !bus.dout_ready);
  assign w_accept    = bus.din_valid && w_din_ready;
  assign w_consume   = valid_q && bus.dout_ready;

  // Next-state: slot steering, word completion, output handshake, clear.
  always_comb begin
    sel_d   = sel_q;
    asm_d   = asm_q;
    dout_d  = dout_q;
    valid_d = valid_q;

    if (w_consume) begin
      valid_d = 1'b0;
    end

    if (bus.clear) begin
      sel_d = '0;
      asm_d = '0;
    end else if (w_accept) begin
      if (w_last) begin
        // Completion overrides a same-edge consume so there is no bubble.
        dout_d  = {bus.din, asm_q};
        valid_d = 1'b1;
        asm_d   = '0;
        sel_d   = '0;
      end else begin
        asm_d[sel_q] = bus.din;
        sel_d        = sel_q + SEL_W'(1);
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= '0;
      asm_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      asm_q   <= asm_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign bus.din_ready  = w_din_ready;
  assign bus.sel        = sel_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_demux8.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_demux8
//  Brief    : Directed + randomised-gap bench for serial_demux8. Expected
//             words are queued when stimulus is issued; a negedge monitor
//             pops and compares whenever a word is consumed.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_demux8;

  localparam int N = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_demux8_if #(.N(N)) bus ();

  logic man_ready = 1'b0;
  logic rnd_ready = 1'b0;
  logic rand_mode = 1'b0;
  assign bus.dout_ready = rand_mode ? rnd_ready : man_ready;

  serial_demux8 #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         errors = 0;
  int         checks = 0;
  int         stalls = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Present one bit and hold it until the DUT accepts it (bounded).
  task automatic send_bit(input logic b);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    bus.din_valid = 1'b1;
    bus.din       = b;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = bus.din_ready;
      @(posedge clk);
      #1;
      if (!acc) begin
        n++;
        stalls++;
      end
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    bus.din_valid = 1'b0;
    bus.din       = 1'bx;
  endtask

  // Send bits lo..hi of v LSB-first with optional random idle gaps; sel must
  // track the number of accepted bits modulo N.
  task automatic send_bits(input logic [7:0] v, input int lo, input int hi, input int maxgap);
    int g;
    for (int i = lo; i <= hi; i++) begin
      g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      repeat (g) begin
        @(posedge clk);
        #1;
      end
      send_bit(v[i]);
      chk("sel_track", 32'(bus.sel), 32'((i + 1) % N));
    end
  endtask

  // Scoreboard monitor: a word is consumed at the edge after this negedge.
  always @(negedge clk) begin
    if (rst_n && bus.dout_valid && bus.dout_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got=%0h expected=none", bus.dout);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("word", 32'(bus.dout), 32'(mon_exp));
      end
    end
  end

  // Random consumer backpressure, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    rnd_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.clear     = 1'b0;
    bus.din_valid = 1'b0;
    bus.din       = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel",   32'(bus.sel),        32'd0);
    chk("rst_dout",  32'(bus.dout),       32'd0);
    chk("rst_valid", 32'(bus.dout_valid), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: 0,1,0,1,... -> 8'hAA one cycle after the 8th bit
    man_ready = 1'b1;
    exp_q.push_back(8'hAA);
    send_bits(8'hAA, 0, 7, 0);
    chk("t1_valid", 32'(bus.dout_valid), 32'd1);
    chk("t1_dout",  32'(bus.dout),       32'hAA);
    @(posedge clk);
    #1;

    // 2: back-to-back words, no stalls, one-cycle valid pulse
    stalls = 0;
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    send_bits(8'hAA, 0, 7, 0);
    send_bits(8'h55, 0, 0, 0);
    chk("t2_valid_pulse", 32'(bus.dout_valid), 32'd0);
    send_bits(8'h55, 1, 7, 0);
    chk("t2_no_stall", 32'(stalls), 32'd0);
    chk("t2_dout", 32'(bus.dout), 32'h55);
    @(posedge clk);
    #1;

    // 3: backpressure on the completing bit, then no-bubble handover
    man_ready = 1'b0;
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h0F);
    send_bits(8'hF0, 0, 7, 0);
    chk("t3_valid_f0", 32'(bus.dout_valid), 32'd1);
    send_bits(8'h0F, 0, 6, 0);
    bus.din_valid = 1'b1;
    bus.din       = 1'b0;
    @(negedge clk);
    chk("t3_stall_ready", 32'(bus.din_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("t3_hold_dout", 32'(bus.dout), 32'hF0);
    chk("t3_hold_sel",  32'(bus.sel),  32'd7);
    man_ready = 1'b1;
    @(negedge clk);
    chk("t3_release_ready", 32'(bus.din_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
    chk("t3_dout_0f",   32'(bus.dout),       32'h0F);
    chk("t3_valid_kept", 32'(bus.dout_valid), 32'd1);
    chk("t3_sel_wrap",  32'(bus.sel),        32'd0);
    @(posedge clk);
    #1;
    chk("t3_valid_drop", 32'(bus.dout_valid), 32'd0);

    // 4: partial word aborted by clear, which also refuses its bit
    send_bits(8'h05, 0, 2, 0);
    bus.clear     = 1'b1;
    bus.din_valid = 1'b1;
    bus.din       = 1'b1;
    @(negedge clk);
    chk("t4_clear_ready", 32'(bus.din_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.clear     = 1'b0;
    bus.din_valid = 1'b0;
    chk("t4_sel_cleared", 32'(bus.sel), 32'd0);
    exp_q.push_back(8'h3C);
    send_bits(8'h3C, 0, 7, 0);
    chk("t4_dout", 32'(bus.dout), 32'h3C);
    @(posedge clk);
    #1;

    // 5: asynchronous reset mid-word
    send_bits(8'hFF, 0, 4, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_sel",   32'(bus.sel),        32'd0);
    chk("t5_rst_dout",  32'(bus.dout),       32'd0);
    chk("t5_rst_valid", 32'(bus.dout_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(8'h81);
    send_bits(8'h81, 0, 7, 0);
    chk("t5_dout", 32'(bus.dout), 32'h81);
    @(posedge clk);
    #1;

    // 6: 1000 words with random input gaps and random backpressure
    rand_mode = 1'b1;
    for (int w = 0; w < 1000; w++) begin
      logic [7:0] v;
      v = 8'($urandom);
      exp_q.push_back(v);
      send_bits(v, 0, 7, 2);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
